// File: rtl/spoc_postproc.sv
// SpoC-64 output post-processor: turns the controller's bdo stream and auth result into
// CAESAR-API do words (header, CT/PT, tag, status). Optional last-word masking: SPOC_POSTPROC_MASK_EN.
module spoc_postproc #(
  parameter int W         = 32,
  parameter int TAG_WORDS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cmd,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] bdo,
  input  logic         bdo_valid,
  output logic         bdo_ready,
  input  logic         end_of_block,
  input  logic         msg_auth,
  input  logic         msg_auth_valid,
  output logic         msg_auth_ready,
  output logic [W-1:0] do_data,
  output logic         do_valid,
  input  logic         do_ready,
  output logic         do_last,
  output logic         proto_err,
  output logic [2:0]   state_dbg
);

  // Handshakes: a word moves on a rising clk edge where valid and ready are both high.
  // Sources hold valid and data stable until that edge; ready may depend on the state only,
  // except in DATA/TAG where bdo_ready is do_ready and do_valid is bdo_valid (same cycle).

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_HDR   = 3'd1,
    HDR       = 3'd2,
    DATA      = 3'd3,
    TAG_HDR   = 3'd4,
    TAG       = 3'd5,
    WAIT_AUTH = 3'd6,
    STATUS    = 3'd7
  } state_t;

  localparam int          TCW   = $clog2(TAG_WORDS + 1);
  localparam logic [TCW-1:0] TAG_CNT = TCW'(TAG_WORDS);
  localparam logic [W-1:0] TAG_HDR_WORD = {4'b1000, 3'b000, 1'b1, 8'h00, 16'd8};
  localparam logic [W-1:0] ST_OK_WORD   = 32'hE000_0000;
  localparam logic [W-1:0] ST_FAIL_WORD = 32'hF000_0000;

  state_t          state, state_n;
  logic            dec_r;
  logic            auth_r;
  logic [15:0]     len_r;
  logic [16:0]     wcnt;
  logic [TCW-1:0]  tcnt;
  logic [3:0]      op;
  logic            op_ok;
  logic            cmd_xfer;
  logic            bdo_xfer;
  logic            last_data;
  logic [W-1:0]    hdr_word;
  logic [W-1:0]    data_out;

  assign op        = cmd[W-1 -: 4];
  assign op_ok     = (op == 4'b0010) || (op == 4'b0011);
  assign cmd_ready = rst && ((state == IDLE) || (state == GET_HDR));
  assign cmd_xfer  = cmd_valid && cmd_ready;
  assign bdo_xfer  = bdo_valid && bdo_ready;
  assign last_data = (wcnt == 17'd1);
  assign hdr_word  = {(dec_r ? 4'b0100 : 4'b0101), 3'b000, dec_r, 8'h00, len_r};
  assign state_dbg = state;

`ifdef SPOC_POSTPROC_MASK_EN
  // Only the final message word of a non-multiple-of-4 length carries unused bytes.
  always_comb begin
    data_out = bdo;
    if (last_data) begin
      case (len_r[1:0])
        2'd1:    data_out = {bdo[W-1 -: 8],  {(W-8){1'b0}}};
        2'd2:    data_out = {bdo[W-1 -: 16], {(W-16){1'b0}}};
        2'd3:    data_out = {bdo[W-1 -: 24], {(W-24){1'b0}}};
        default: data_out = bdo;
      endcase
    end
  end
`else
  assign data_out = bdo;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n        = state;
    bdo_ready      = 1'b0;
    msg_auth_ready = 1'b0;
    do_valid       = 1'b0;
    do_data        = '0;
    do_last        = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_xfer && op_ok) state_n = GET_HDR;
      end
      GET_HDR: begin
        if (cmd_xfer) state_n = HDR;
      end
      HDR: begin
        do_valid = 1'b1;
        do_data  = hdr_word;
        if (do_ready) begin
          if (wcnt != 17'd0) state_n = DATA;
          else               state_n = dec_r ? WAIT_AUTH : TAG_HDR;
        end
      end
      DATA: begin
        do_valid  = bdo_valid;
        bdo_ready = do_ready;
        do_data   = data_out;
        if (bdo_xfer && last_data) state_n = dec_r ? WAIT_AUTH : TAG_HDR;
      end
      TAG_HDR: begin
        do_valid = 1'b1;
        do_data  = TAG_HDR_WORD;
        if (do_ready) state_n = TAG;
      end
      TAG: begin
        do_valid  = bdo_valid;
        bdo_ready = do_ready;
        do_data   = bdo;
        if (bdo_xfer && (tcnt == TCW'(1))) state_n = STATUS;
      end
      WAIT_AUTH: begin
        msg_auth_ready = 1'b1;
        if (msg_auth_valid) state_n = STATUS;
      end
      STATUS: begin
        do_valid = 1'b1;
        do_last  = 1'b1;
        do_data  = (dec_r && !auth_r) ? ST_FAIL_WORD : ST_OK_WORD;
        if (do_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_r     <= 1'b0;
      auth_r    <= 1'b0;
      len_r     <= '0;
      wcnt      <= '0;
      tcnt      <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_xfer) begin
            if (op_ok) dec_r <= (op == 4'b0011);
            else       proto_err <= 1'b1;
          end
        end
        GET_HDR: begin
          if (cmd_xfer) begin
            len_r <= cmd[15:0];
            wcnt  <= ({1'b0, cmd[15:0]} + 17'd3) >> 2;
          end
        end
        DATA: begin
          if (bdo_xfer) begin
            wcnt <= wcnt - 17'd1;
            // The word is forwarded either way; a misplaced end_of_block only flags.
            if (end_of_block != last_data) proto_err <= 1'b1;
          end
        end
        TAG_HDR: begin
          if (do_ready) tcnt <= TAG_CNT;
        end
        TAG: begin
          if (bdo_xfer) tcnt <= tcnt - TCW'(1);
        end
        WAIT_AUTH: begin
          if (msg_auth_valid) auth_r <= msg_auth;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spoc_postproc.sv
// Self-checking bench for spoc_postproc: scoreboard of expected do words, protocol monitors,
// directed and random packets, reset checks. Honours SPOC_POSTPROC_MASK_EN when defined.
module tb_spoc_postproc;
  localparam int W  = 32;
  localparam int TW = 2;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_DATA = 3'd3, ST_TAG = 3'd5, ST_WAIT_AUTH = 3'd6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] cmd = '0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] bdo = '0;
  logic         bdo_valid = 1'b0;
  logic         bdo_ready;
  logic         end_of_block = 1'b0;
  logic         msg_auth = 1'b0;
  logic         msg_auth_valid = 1'b0;
  logic         msg_auth_ready;
  logic [W-1:0] do_data;
  logic         do_valid;
  logic         do_ready;
  logic         do_last;
  logic         proto_err;
  logic [2:0]   state_dbg;

  int n_checks = 0;
  int n_bad    = 0;
  int ready_mode = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] dwords[0:15];
  logic [W-1:0] tags[0:TW-1];
  logic [W-1:0] held_data;
  bit           stalled = 0;

  spoc_postproc #(.W(W), .TAG_WORDS(TW)) dut (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
    .end_of_block(end_of_block),
    .msg_auth(msg_auth), .msg_auth_valid(msg_auth_valid), .msg_auth_ready(msg_auth_ready),
    .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready), .do_last(do_last),
    .proto_err(proto_err), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // downstream ready: 0 = always, 1 = toggle every cycle, 2 = random
  initial begin
    do_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       do_ready = 1'b1;
        1:       do_ready = ~do_ready;
        default: do_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      check("bdo_ready", {63'b0, bdo_ready},
            (state_dbg == ST_DATA || state_dbg == ST_TAG) ? {63'b0, do_ready} : 64'd0);
      check("auth_ready", {63'b0, msg_auth_ready}, {63'b0, state_dbg == ST_WAIT_AUTH});
      if (stalled) begin
        check("hold_valid", {63'b0, do_valid}, 64'd1);
        check("hold_data", {32'b0, do_data}, {32'b0, held_data});
      end
      if (do_valid && do_ready) begin
        if (exp_q.size() == 0) check("extra_word", {63'b0, do_valid}, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("do_word", {31'b0, do_last, do_data}, {31'b0, e});
        end
      end
      stalled   = do_valid && !do_ready;
      held_data = do_data;
    end else begin
      stalled = 0;
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [W-1:0] c);
    int t = 0;
    bit ok = 0;
    cmd = c; cmd_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1; t++;
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_timeout", {63'b0, ok}, 64'd1);
  endtask

  task automatic send_bdo(input logic [W-1:0] w, input logic eob);
    int t = 0;
    bit ok = 0;
    bdo = w; end_of_block = eob; bdo_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk); ok = bdo_ready;
      @(posedge clk); #1; t++;
    end
    bdo_valid = 1'b0; end_of_block = 1'b0;
    if (!ok) check("bdo_timeout", {63'b0, ok}, 64'd1);
  endtask

  task automatic send_auth();
    int t = 0;
    bit ok = 0;
    msg_auth_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk); ok = msg_auth_ready;
      @(posedge clk); #1; t++;
    end
    msg_auth_valid = 1'b0;
    if (!ok) check("auth_timeout", {63'b0, ok}, 64'd1);
  endtask

  task automatic push_pkt(input bit dec, input logic [15:0] l16, input bit pass);
    int nw;
    logic [W-1:0] e;
    nw = (int'(l16) + 3) / 4;
    exp_q.push_back({1'b0, (dec ? 8'h41 : 8'h50), 8'h00, l16});
    for (int i = 0; i < nw; i++) begin
      e = dwords[i];
`ifdef SPOC_POSTPROC_MASK_EN
      if (i == nw - 1) begin
        case (l16[1:0])
          2'd1: e = e & 32'hFF00_0000;
          2'd2: e = e & 32'hFFFF_0000;
          2'd3: e = e & 32'hFFFF_FF00;
          default: ;
        endcase
      end
`endif
      exp_q.push_back({1'b0, e});
    end
    if (!dec) begin
      exp_q.push_back({1'b0, 32'h8100_0008});
      for (int i = 0; i < TW; i++) exp_q.push_back({1'b0, tags[i]});
    end
    exp_q.push_back({1'b1, (dec && !pass) ? 32'hF000_0000 : 32'hE000_0000});
  endtask

  // bad_eob >= 0 raises end_of_block on that word index instead of the last one
  task automatic run_pkt(input bit dec, input int len, input bit pass, input int bad_eob);
    int nw;
    int t = 0;
    logic [15:0] l16;
    l16 = len[15:0];
    nw  = (len + 3) / 4;
    push_pkt(dec, l16, pass);
    if (dec) begin
      msg_auth = pass;
      msg_auth_valid = 1'b1;   // presented early; must be held off until WAIT_AUTH
    end
    send_cmd({(dec ? 4'h3 : 4'h2), 28'h0});
    send_cmd({16'h0, l16});
    for (int i = 0; i < nw; i++)
      send_bdo(dwords[i], (bad_eob >= 0) ? (i == bad_eob) : (i == nw - 1));
    if (!dec) for (int i = 0; i < TW; i++) send_bdo(tags[i], i == TW - 1);
    else      send_auth();
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    check("drain", exp_q.size(), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) dwords[i] = $urandom;
    for (int i = 0; i < TW; i++) tags[i] = $urandom;
  endtask

  initial begin
    // reset state
    #3;
    check("rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    check("rst_do_valid", {63'b0, do_valid}, 64'd0);
    check("rst_do_data", {32'b0, do_data}, 64'd0);
    check("rst_proto_err", {63'b0, proto_err}, 64'd0);
    check("rst_bdo_ready", {63'b0, bdo_ready}, 64'd0);
    check("rst_auth_ready", {63'b0, msg_auth_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    @(posedge clk); #1;

    // encrypt len=8
    dwords[0] = 32'h1111_1111; dwords[1] = 32'h2222_2222;
    tags[0] = 32'hAAAA_0001;   tags[1] = 32'hAAAA_0002;
    run_pkt(0, 8, 1, -1);
    // decrypt pass len=5
    dwords[0] = 32'h0102_0304; dwords[1] = 32'hDEAD_BEEF;
    run_pkt(1, 5, 1, -1);
    // decrypt fail len=0
    run_pkt(1, 0, 0, -1);
    // back-pressure: 8-word CT with do_ready toggling
    ready_mode = 1;
    fill_random();
    run_pkt(0, 32, 1, -1);
    // random traffic
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      fill_random();
      run_pkt(1'($urandom_range(0, 1)), $urandom_range(0, 40), 1'($urandom_range(0, 1)), -1);
    end
    ready_mode = 0;
    @(negedge clk);
    check("no_err_yet", {63'b0, proto_err}, 64'd0);
    @(posedge clk); #1;

    // bad opcode
    send_cmd(32'h7000_0000);
    @(negedge clk);
    check("badop_err", {63'b0, proto_err}, 64'd1);
    check("badop_state", {61'b0, state_dbg}, {61'b0, ST_IDLE});
    check("badop_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    fill_random();
    run_pkt(0, 7, 1, -1);
    check("err_sticky", {63'b0, proto_err}, 64'd1);
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("err_cleared", {63'b0, proto_err}, 64'd0);

    // end_of_block on word 1 of a 3-word CT
    fill_random();
    run_pkt(0, 12, 1, 0);
    check("eob_err", {63'b0, proto_err}, 64'd1);

    // reset mid-DATA after 2 of 4 words
    fill_random();
    push_pkt(0, 16'd16, 1);
    send_cmd(32'h2000_0000);
    send_cmd(32'h0000_0010);
    send_bdo(dwords[0], 1'b0);
    send_bdo(dwords[1], 1'b0);
    bdo = dwords[2]; bdo_valid = 1'b1;
    #1 check("pre_rst_do_valid", {63'b0, do_valid}, 64'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_do_valid", {63'b0, do_valid}, 64'd0);
    check("mid_rst_proto_err", {63'b0, proto_err}, 64'd0);
    check("mid_rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    bdo_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    fill_random();
    run_pkt(0, 16, 1, -1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/spoc_postproc.md
# spoc_postproc

Output post-processor for the SpoC-64 CAESAR core, directly downstream of the SpoC controller/datapath. Consumes the controller's `bdo` word stream, `end_of_block` and `msg_auth_valid`, plus the instruction/segment headers forwarded by the pre-processor on a command channel. Emits CAESAR-API public-output (`do`) traffic: segment headers, CT/PT words, the tag (encrypt only) and a final status word.

## Interface
Parameters:
- `W`, 32, data word width. Only 32 is supported.
- `TAG_WORDS`, 2, tag length in `W`-bit words (64-bit tag).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd`  in  32  instruction or segment header from the pre-processor.
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake.
- `bdo`  in  32  output block data from the datapath.
- `bdo_valid` / `bdo_ready`  in / out  1  bdo handshake.
- `end_of_block`  in  1  controller marks the last CT/PT word; also marks the last tag word.
- `msg_auth`  in  1  tag comparison result, 1 = pass.
- `msg_auth_valid` / `msg_auth_ready`  in / out  1  authentication result handshake.
- `do_data`  out  32  output word.
- `do_valid` / `do_ready`  out / in  1  output handshake.
- `do_last`  out  1  set with the status word.
- `proto_err`  out  1  sticky protocol error flag.

## Operation
- A transfer occurs when valid and ready are both high on the same rising edge of `clk`.
- States: IDLE, GET_HDR, HDR, DATA, TAG_HDR, TAG, WAIT_AUTH, STATUS.
- **IDLE**
  - `cmd_ready`=1.
  - On a `cmd` transfer, latch `dec_r` = (`cmd[31:28]`==4'b0011), then go to GET_HDR.
  - Any opcode other than 4'b0010/4'b0011 sets `proto_err` and the state stays in IDLE.
- **GET_HDR**
  - `cmd_ready`=1.
  - On transfer, latch `len_r` = `cmd[15:0]` (message bytes).
  - Load `wcnt` = (`len_r`+3)>>2, computed 17-bit with no overflow.
  - Go to HDR.
- **HDR**
  - Drive `do_data` = {type, 3'b0, last, 8'h00, `len_r`}.
    - type = 4'b0101 (CT) on encrypt, 4'b0100 (PT) on decrypt.
    - last = `dec_r`.
  - On transfer:
    - `wcnt`≠0 goes to DATA.
    - `wcnt`=0 goes to TAG_HDR on encrypt, WAIT_AUTH on decrypt.
- **DATA**
  - Pass-through: `do_data`=`bdo`, `do_valid`=`bdo_valid`, `bdo_ready`=`do_ready`.
  - Each transfer decrements `wcnt`.
  - On the transfer with `wcnt`==1, leave to TAG_HDR (encrypt) or WAIT_AUTH (decrypt).
  - Last-word masking: see Configuration.
  - `end_of_block` high on a transfer with `wcnt`≠1, or low on the transfer with `wcnt`==1, sets `proto_err`. The data is still forwarded.
- **TAG_HDR**
  - Drive {4'b1000, 3'b0, 1'b1, 8'h00, 16'd8}.
  - On transfer, go to TAG with the tag counter = `TAG_WORDS`.
- **TAG**
  - Same pass-through as DATA for `TAG_WORDS` words, then go to STATUS.
- **WAIT_AUTH**
  - `msg_auth_ready`=1.
  - On transfer, latch `auth_r` = `msg_auth`, then go to STATUS.
- **STATUS**
  - `do_data` = 32'hE000_0000 on encrypt or on decrypt pass; 32'hF000_0000 on decrypt fail.
  - `do_last`=1.
  - On transfer, go to IDLE.
- `proto_err` clears only on reset.

## Timing
- Reset values:
  - state = IDLE.
  - `do_valid`, `do_last`, `bdo_ready`, `cmd_ready`, `msg_auth_ready` and `proto_err` = 0.
  - `do_data` = 0.
  - `wcnt` = 0.
- After reset release, `cmd_ready`=1 in the first cycle.
- DATA and TAG: zero-cycle combinational pass-through.
  - `do_valid` follows `bdo_valid` in the same cycle.
  - Back-pressure from `do_ready` reaches `bdo_ready` in the same cycle.
- HDR, TAG_HDR and STATUS words come from registers.
  - `do_valid`=1 from the first cycle in the state.
  - `do_data` is held stable until the transfer.
- `bdo_ready`=0 outside DATA/TAG, so the controller stalls in WRITE_PTCT and FINISH_TAG.
- `msg_auth_ready`=0 outside WAIT_AUTH.
- Throughput: one word per cycle in DATA/TAG when `bdo_valid` and `do_ready` are continuously high.
- Asynchronous reset mid-packet returns the block to IDLE immediately. Partial output is abandoned and no status word is emitted.
- `msg_auth_valid` arriving before WAIT_AUTH is not accepted; it is held off by `msg_auth_ready`=0.

## Configuration
- Macro: `SPOC_POSTPROC_MASK_EN`.
- Defined: on the final DATA word with `len_r[1:0]`≠0, zero the unused low-order bytes.
  - `len_r[1:0]`=1 keeps [31:24].
  - `len_r[1:0]`=2 keeps [31:16].
  - `len_r[1:0]`=3 keeps [31:8].
- Undefined: the final word is forwarded unmodified. No masking logic is synthesised.

## Test plan
- **Encrypt, len=8:** cmd 32'h2000_0000 then 32'h0000_0008; bdo 32'h11111111, 32'h22222222 (eob on 2nd); tag 32'hAAAA0001, 32'hAAAA0002 -> do: 32'h5000_0008, 32'h11111111, 32'h22222222, 32'h8100_0008, 32'hAAAA0001, 32'hAAAA0002, 32'hE000_0000 with `do_last`=1.
- **Decrypt pass, len=5, macro defined:** last bdo 32'hDEADBEEF -> do: 32'h4100_0005, first word, 32'hDE00_0000; then `msg_auth`=1 -> 32'hE000_0000.
- **Decrypt fail, len=0:** header 32'h4100_0000, no data words; `msg_auth`=0 -> status 32'hF000_0000, `do_last`=1.
- **Back-pressure:** `do_ready` toggles 1/0 every cycle during an 8-word CT -> `bdo_ready` mirrors `do_ready` in the same cycle, no word dropped or duplicated, header held stable while stalled.
- **Protocol error:** `end_of_block`=1 on word 1 of a 3-word CT -> `proto_err`=1 and stays 1; all 3 words still forwarded. Bad opcode 32'h7000_0000 -> `proto_err`=1 and the state stays in IDLE.
- **Reset mid-DATA:** `rst`=0 after 2 of 4 words -> `do_valid`=0, `proto_err`=0 and `cmd_ready`=0 asynchronously; `cmd_ready`=1 in the first cycle after release.
